mem_port_arbiter: RTL and testbench

Single-port memory arbiter for the pipelined core. It shares the unified instruction/data memory between three requesters:
- the instruction-fetch stage (F);
- the memory-access stage (D);
- the external program loader (L).

One transaction is outstanding at a time. Arbitration is fixed-priority with a fetch anti-starvation guard, and a halt-gated loader window. It sits between the pipeline stage latches and the memory macro.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus between the F/D/L requesters, the arbiter and the memory macro.
// Fetch always reads, so it carries no write enable or write data.
interface mem_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          f_req, f_gnt, f_rvalid;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;

    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;

    logic          l_req, l_we, l_gnt, l_rvalid;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata;

    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy_o;

    modport master (
        output f_req, f_addr,
        output d_req, d_we, d_addr, d_wdata,
        output l_req, l_we, l_addr, l_wdata,
        output mem_rdata,
        input  f_gnt, f_rvalid, f_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy_o
    );

    modport slave (
        input  f_req, f_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  l_req, l_we, l_addr, l_wdata,
        input  mem_rdata,
        output f_gnt, f_rvalid, f_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch, memory stage and loader share one memory,
// one transaction at a time, D-over-F priority with a fetch starvation guard.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 halted_i,
    mem_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
    typedef enum logic [1:0] {OWN_F, OWN_D, OWN_L} owner_t;

    localparam logic [2:0] WAIT_INIT  = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    owner_t     owner;
    logic       cap_we;
    logic [2:0] wait_cnt;
    logic [3:0] starve_cnt;

    logic win_f, win_d, win_l, last_cycle;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        win_f      = 1'b0;
        win_d      = 1'b0;
        win_l      = 1'b0;
        last_cycle = 1'b0;
        if (halted_i) begin
            win_l = bus.l_req;
        end else begin
            win_f = bus.f_req && (!bus.d_req || starve_cnt == STARVE_LIM);
            win_d = bus.d_req && !win_f;
        end
        if (state == ACCESS && MEM_LAT == 1)
            last_cycle = 1'b1;
        else if (state == WAIT && wait_cnt == 3'd1)
            last_cycle = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            owner          <= OWN_F;
            cap_we         <= 1'b0;
            wait_cnt       <= '0;
            starve_cnt     <= '0;
            bus.f_gnt      <= 1'b0;
            bus.d_gnt      <= 1'b0;
            bus.l_gnt      <= 1'b0;
            bus.f_rvalid   <= 1'b0;
            bus.d_rvalid   <= 1'b0;
            bus.l_rvalid   <= 1'b0;
            bus.f_rdata    <= '0;
            bus.d_rdata    <= '0;
            bus.l_rdata    <= '0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.busy_o     <= 1'b0;
        end else begin
            bus.f_gnt    <= 1'b0;
            bus.d_gnt    <= 1'b0;
            bus.l_gnt    <= 1'b0;
            bus.f_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.l_rvalid <= 1'b0;
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;

            case (state)
                IDLE: begin
                    if (!bus.f_req)
                        starve_cnt <= '0;
                    if (win_f || win_d || win_l) begin
                        state      <= ACCESS;
                        bus.busy_o <= 1'b1;
                        bus.mem_en <= 1'b1;
                    end
                    if (win_f) begin
                        owner        <= OWN_F;
                        cap_we       <= 1'b0;
                        bus.f_gnt    <= 1'b1;
                        bus.mem_addr <= bus.f_addr;
                        starve_cnt   <= '0;
                    end else if (win_d) begin
                        owner         <= OWN_D;
                        cap_we        <= bus.d_we;
                        bus.d_gnt     <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        // Each D grant that passes over a waiting F brings F's turn closer.
                        if (bus.f_req && starve_cnt != STARVE_LIM)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (win_l) begin
                        owner         <= OWN_L;
                        cap_we        <= bus.l_we;
                        bus.l_gnt     <= 1'b1;
                        bus.mem_we    <= bus.l_we;
                        bus.mem_addr  <= bus.l_addr;
                        bus.mem_wdata <= bus.l_wdata;
                    end
                end

                ACCESS, WAIT: begin
                    if (last_cycle) begin
                        state      <= IDLE;
                        bus.busy_o <= 1'b0;
                        if (!cap_we) begin
                            case (owner)
                                OWN_F: begin
                                    bus.f_rdata  <= bus.mem_rdata;
                                    bus.f_rvalid <= 1'b1;
                                end
                                OWN_D: begin
                                    bus.d_rdata  <= bus.mem_rdata;
                                    bus.d_rvalid <= 1'b1;
                                end
                                default: begin
                                    bus.l_rdata  <= bus.mem_rdata;
                                    bus.l_rvalid <= 1'b1;
                                end
                            endcase
                        end
                    end else if (state == ACCESS) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3, each with
// a small behavioural memory; expected values are hand-computed.
module tb_mem_port_arbiter;
    logic clk1;
    logic rst_n;
    logic halted_i;

    int vectors     = 0;
    int miscompares = 0;

    mem_port_arbiter_if #(.AW(10), .DW(32)) bus1 ();
    mem_port_arbiter_if #(.AW(10), .DW(32)) bus3 ();

    mem_port_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk1(clk1), .rst_n(rst_n), .halted_i(halted_i), .bus(bus1)
    );
    mem_port_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk1(clk1), .rst_n(rst_n), .halted_i(halted_i), .bus(bus3)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Preloaded memory contents used by the directed vectors.
    function automatic logic [31:0] rom(input logic [9:0] a);
        case (a)
            10'h005: rom = 32'hDEADBEEF;
            10'h007: rom = 32'h11111111;
            10'h009: rom = 32'h22222222;
            10'h010: rom = 32'hCAFEF00D;
            10'h011: rom = 32'hA5A5A5A5;
            default: rom = {22'h0, a};
        endcase
    endfunction

    // Latency-1 memory: data for the address strobed this cycle, writes stored.
    bit   [31:0] wdat1 [1024];
    bit          wvld1 [1024];
    logic [9:0]  hold1;
    logic [9:0]  rdaddr1;
    always @(posedge clk1) begin
        if (bus1.mem_en) begin
            hold1 <= bus1.mem_addr;
            if (bus1.mem_we) begin
                wdat1[bus1.mem_addr] <= bus1.mem_wdata;
                wvld1[bus1.mem_addr] <= 1'b1;
            end
        end
    end
    always_comb begin
        rdaddr1        = bus1.mem_en ? bus1.mem_addr : hold1;
        bus1.mem_rdata = wvld1[rdaddr1] ? wdat1[rdaddr1] : rom(rdaddr1);
    end

    // Latency-3 memory: data valid only in the second cycle after the strobe cycle.
    logic [2:0] lat3 = 3'd0;
    logic [9:0] hold3;
    always @(posedge clk1) begin
        if (bus3.mem_en) begin
            lat3  <= 3'd1;
            hold3 <= bus3.mem_addr;
        end else if (lat3 != 3'd0 && lat3 != 3'd7) begin
            lat3 <= lat3 + 3'd1;
        end
    end
    assign bus3.mem_rdata = (lat3 == 3'd2) ? rom(hold3) : 32'h0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk1);
    endtask

    initial begin
        int n;
        rst_n    = 1'b1;
        halted_i = 1'b0;
        bus1.f_req = 0; bus1.f_addr = '0;
        bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
        bus1.l_req = 0; bus1.l_we = 0; bus1.l_addr = '0; bus1.l_wdata = '0;
        bus3.f_req = 0; bus3.f_addr = '0;
        bus3.d_req = 0; bus3.d_we = 0; bus3.d_addr = '0; bus3.d_wdata = '0;
        bus3.l_req = 0; bus3.l_we = 0; bus3.l_addr = '0; bus3.l_wdata = '0;
        #1 rst_n = 1'b0;

        // Reset state
        cyc();
        check("rst_busy", bus1.busy_o, 0);
        check("rst_mem_en", bus1.mem_en, 0);
        check("rst_gnt", {bus1.f_gnt, bus1.d_gnt, bus1.l_gnt}, 0);
        check("rst_rvalid", {bus1.f_rvalid, bus1.d_rvalid, bus1.l_rvalid}, 0);
        check("rst_mem_addr", bus1.mem_addr, 0);
        check("rst_f_rdata", bus1.f_rdata, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single fetch read, MEM_LAT=1
        bus1.f_req = 1; bus1.f_addr = 10'h005;
        check("f1_busy_T", bus1.busy_o, 0);
        cyc();
        check("f1_gnt", bus1.f_gnt, 1);
        check("f1_mem_en", bus1.mem_en, 1);
        check("f1_mem_we", bus1.mem_we, 0);
        check("f1_mem_addr", bus1.mem_addr, 32'h5);
        check("f1_busy", bus1.busy_o, 1);
        bus1.f_req = 0;
        cyc();
        check("f1_rvalid", bus1.f_rvalid, 1);
        check("f1_rdata", bus1.f_rdata, 32'hDEADBEEF);
        check("f1_busy_end", bus1.busy_o, 0);
        check("f1_gnt_end", bus1.f_gnt, 0);
        cyc();
        check("f1_rvalid_pulse", bus1.f_rvalid, 0);
        check("f1_rdata_hold", bus1.f_rdata, 32'hDEADBEEF);

        // Simultaneous F and D: D first, F at T+3
        bus1.f_req = 1; bus1.f_addr = 10'h009;
        bus1.d_req = 1; bus1.d_addr = 10'h007; bus1.d_we = 0;
        cyc();
        check("fd_d_gnt", bus1.d_gnt, 1);
        check("fd_f_gnt_T1", bus1.f_gnt, 0);
        check("fd_addr_d", bus1.mem_addr, 32'h7);
        bus1.d_req = 0;
        cyc();
        check("fd_d_rvalid", bus1.d_rvalid, 1);
        check("fd_d_rdata", bus1.d_rdata, 32'h11111111);
        check("fd_f_gnt_T2", bus1.f_gnt, 0);
        cyc();
        check("fd_f_gnt_T3", bus1.f_gnt, 1);
        check("fd_addr_f", bus1.mem_addr, 32'h9);
        bus1.f_req = 0;
        cyc();
        check("fd_f_rvalid", bus1.f_rvalid, 1);
        check("fd_f_rdata", bus1.f_rdata, 32'h22222222);
        cyc();

        // Starvation guard: D,D,D,D,F repeating
        bus1.f_req = 1; bus1.d_req = 1;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            check($sformatf("starve_overlap%0d", c),
                  (bus1.f_gnt | bus1.d_gnt) & (bus1.f_rvalid | bus1.d_rvalid), 0);
            if (bus1.f_gnt || bus1.d_gnt) begin
                check($sformatf("starve_gnt%0d", n), {bus1.f_gnt, bus1.d_gnt},
                      (n % 5 == 4) ? 32'd2 : 32'd1);
                n++;
            end
        end
        bus1.f_req = 0; bus1.d_req = 0;
        check("starve_count", n, 10);
        cyc();
        cyc();

        // Loader window: halted, L write while F requests
        halted_i = 1;
        bus1.f_req = 1; bus1.f_addr = 10'h005;
        bus1.l_req = 1; bus1.l_we = 1; bus1.l_addr = 10'h3FF; bus1.l_wdata = 32'h12345678;
        cyc();
        check("ld_l_gnt", bus1.l_gnt, 1);
        check("ld_f_gnt", bus1.f_gnt, 0);
        check("ld_mem_we", bus1.mem_we, 1);
        check("ld_mem_addr", bus1.mem_addr, 32'h3FF);
        check("ld_mem_wdata", bus1.mem_wdata, 32'h12345678);
        bus1.l_req = 0;
        cyc();
        check("ld_no_rvalid", bus1.l_rvalid, 0);
        cyc();
        check("ld_f_blocked", bus1.f_gnt, 0);
        halted_i = 0; bus1.f_req = 0;
        bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 10'h3FF;
        cyc();
        check("ld_d_gnt", bus1.d_gnt, 1);
        bus1.d_req = 0;
        cyc();
        check("ld_d_rvalid", bus1.d_rvalid, 1);
        check("ld_d_rdata", bus1.d_rdata, 32'h12345678);
        cyc();

        // MEM_LAT=3 read
        bus3.d_req = 1; bus3.d_we = 0; bus3.d_addr = 10'h010;
        cyc();
        check("l3_gnt", bus3.d_gnt, 1);
        check("l3_busy1", bus3.busy_o, 1);
        bus3.d_req = 0;
        cyc();
        check("l3_busy2", bus3.busy_o, 1);
        check("l3_rvalid2", bus3.d_rvalid, 0);
        cyc();
        check("l3_busy3", bus3.busy_o, 1);
        check("l3_rvalid3", bus3.d_rvalid, 0);
        cyc();
        check("l3_rvalid4", bus3.d_rvalid, 1);
        check("l3_rdata", bus3.d_rdata, 32'hCAFEF00D);
        check("l3_busy4", bus3.busy_o, 0);

        // Reset during WAIT
        bus3.d_req = 1; bus3.d_addr = 10'h011;
        cyc();
        check("rw_gnt", bus3.d_gnt, 1);
        bus3.d_req = 0;
        cyc();
        rst_n = 0;
        #1;
        check("rw_busy", bus3.busy_o, 0);
        check("rw_mem_en", bus3.mem_en, 0);
        check("rw_rvalid", bus3.d_rvalid, 0);
        check("rw_rdata", bus3.d_rdata, 0);
        check("rw_mem_addr", bus3.mem_addr, 0);
        cyc();
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            check($sformatf("rw_quiet%0d", c), {bus3.d_rvalid, bus3.busy_o}, 0);
        end
        bus3.d_req = 1; bus3.d_addr = 10'h010;
        cyc();
        check("rw_new_gnt", bus3.d_gnt, 1);
        bus3.d_req = 0;
        cyc();
        cyc();
        cyc();
        check("rw_new_rvalid", bus3.d_rvalid, 1);
        check("rw_new_rdata", bus3.d_rdata, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
